// File: rtl/loopback_interceptor.sv
// -----------------------------------------------------------------------------
// loopback_interceptor
//
// Sits between the post office (send/receive queues) and the bus
// communication interface.
//
// Send side: a message addressed to this core (address == core_id) is diverted
// into a small loopback FIFO instead of going onto the bus. Every other message
// passes straight through to the bus interface, with no latency and no state.
//
// Receive side: bus-received messages and looped-back messages are merged into
// one receive stream toward the post office. A locked round-robin arbiter does
// the merging. Once a source is offered and not taken, the arbiter stays on
// that source until the transfer completes.
//
// Ports:
//   clk, rst, flush                 clock, sync active-high reset, sync flush
//   core_id[31:0]                   this core's address (quasi-static)
//   postoffice_loopback_*           send request from the post office
//   loopback_interface_*            send toward the bus interface
//   interface_loopback_*            message received from the bus
//   loopback_postoffice_*           merged receive stream to the post office
// Message layout (128 bits): address[127:96], tag[95:64], data[63:0].
// On the receive side the address field holds the source address.
// -----------------------------------------------------------------------------
module loopback_interceptor #(
    parameter int LOOPBACK_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [31:0]  core_id,

    input  logic         postoffice_loopback_valid,
    output logic         loopback_postoffice_ready,
    input  logic [127:0] postoffice_loopback_data,

    output logic         loopback_interface_valid,
    input  logic         interface_loopback_ready,
    output logic [127:0] loopback_interface_data,

    input  logic         interface_loopback_valid,
    output logic         loopback_interface_ready,
    input  logic [127:0] interface_loopback_data,

    output logic         loopback_postoffice_valid,
    input  logic         postoffice_loopback_ready,
    output logic [127:0] loopback_postoffice_data
);

    // A depth of 1 still needs a 1-bit pointer.
    localparam int PTR_W = (LOOPBACK_DEPTH > 1) ? $clog2(LOOPBACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(LOOPBACK_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LOOPBACK_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LOOPBACK_DEPTH);

    typedef enum logic {
        SRC_BUS  = 1'b0,
        SRC_LOOP = 1'b1
    } src_e;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic               is_self;
    logic               fifo_full;
    logic               fifo_empty;
    logic               enq;
    logic               deq;
    logic [127:0]       enq_data;
    logic [127:0]       head_data;

    logic [127:0]       mem_reg [LOOPBACK_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic               prio_l_reg, prio_l_next;
    logic               lock_reg, lock_next;
    src_e               lock_src_reg, lock_src_next;

    logic               bus_valid;
    logic               loop_valid;
    logic               grant_any;
    src_e               grant_src;
    logic               rx_valid;
    logic               rx_handshake;

    // Wrap-around increment; the depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Send side: self detection and steering
    // -------------------------------------------------------------------------
    assign is_self = (postoffice_loopback_data[127:96] == core_id);

    assign loopback_interface_valid = postoffice_loopback_valid && !is_self;
    assign loopback_interface_data  = postoffice_loopback_data;

    // The self path depends only on FIFO occupancy and flush. It never depends
    // on the receive-side ready, so a full FIFO refuses the send even when an
    // entry leaves in the same cycle. This keeps the send ready free of any
    // combinational path from the receive ready.
    assign loopback_postoffice_ready = is_self ? (!fifo_full && !flush)
                                               : interface_loopback_ready;

    assign enq = postoffice_loopback_valid && is_self && !fifo_full && !flush;

    // The receive address field carries the source, which is this core.
    assign enq_data = {core_id, postoffice_loopback_data[95:0]};

    // -------------------------------------------------------------------------
    // Loopback FIFO
    // -------------------------------------------------------------------------
    assign fifo_full  = (count_reg == FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign head_data  = mem_reg[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (enq) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (deq) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        // Enqueue together with dequeue leaves the occupancy unchanged.
        case ({enq, deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset. The pointers and count alone decide what is live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_reg[wr_ptr_reg] <= enq_data;
        end
    end

    // -------------------------------------------------------------------------
    // Receive arbiter
    // -------------------------------------------------------------------------
    assign bus_valid  = interface_loopback_valid;
    // Flush hides the FIFO from arbitration for that cycle.
    assign loop_valid = !fifo_empty && !flush;

    always_comb begin
        grant_any = 1'b0;
        grant_src = SRC_BUS;
        if (lock_reg) begin
            grant_any = 1'b1;
            grant_src = lock_src_reg;
        end else if (loop_valid && (!bus_valid || prio_l_reg)) begin
            grant_any = 1'b1;
            grant_src = SRC_LOOP;
        end else if (bus_valid) begin
            grant_any = 1'b1;
            grant_src = SRC_BUS;
        end
    end

    // A bus grant follows the bus valid as-is. If the bus withdraws while
    // locked, the output valid drops and the lock is released below.
    assign rx_valid = grant_any &&
                      ((grant_src == SRC_LOOP) ? loop_valid : bus_valid);

    assign loopback_postoffice_valid = rx_valid;
    assign loopback_postoffice_data  = !grant_any ? '0 :
                                       (grant_src == SRC_LOOP) ? head_data
                                                               : interface_loopback_data;

    assign loopback_interface_ready = postoffice_loopback_ready && grant_any &&
                                      (grant_src == SRC_BUS);
    assign deq = postoffice_loopback_ready && grant_any &&
                 (grant_src == SRC_LOOP) && loop_valid;

    assign rx_handshake = rx_valid && postoffice_loopback_ready;

    always_comb begin
        prio_l_next   = prio_l_reg;
        lock_next     = lock_reg;
        lock_src_next = lock_src_reg;
        if (rx_handshake) begin
            // The source that was just served loses priority next time.
            prio_l_next = (grant_src == SRC_BUS);
            lock_next   = 1'b0;
        end else if (rx_valid) begin
            // The source was offered but not taken, so stay on it.
            lock_next     = 1'b1;
            lock_src_next = grant_src;
        end else begin
            lock_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers: rst and flush both clear the state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            prio_l_reg   <= 1'b0;
            lock_reg     <= 1'b0;
            lock_src_reg <= SRC_BUS;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            prio_l_reg   <= prio_l_next;
            lock_reg     <= lock_next;
            lock_src_reg <= lock_src_next;
        end
    end

endmodule

// File: tb/tb_loopback_interceptor.sv
// -----------------------------------------------------------------------------
// tb_loopback_interceptor
//
// Directed bench for loopback_interceptor with LOOPBACK_DEPTH = 2. Inputs are
// driven 1 ns after the rising edge. Outputs are checked once the
// combinational logic has settled, well away from the edge.
// -----------------------------------------------------------------------------
module tb_loopback_interceptor;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [31:0]  core_id;
    logic         po_valid;
    logic         po_ready;
    logic [127:0] po_data;
    logic         if_valid;
    logic         if_ready;
    logic [127:0] if_data;
    logic         bus_valid;
    logic         bus_ready;
    logic [127:0] bus_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [127:0] rx_data;

    int checks = 0;
    int errors = 0;

    loopback_interceptor #(.LOOPBACK_DEPTH(2)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .flush                     (flush),
        .core_id                   (core_id),
        .postoffice_loopback_valid (po_valid),
        .loopback_postoffice_ready (po_ready),
        .postoffice_loopback_data  (po_data),
        .loopback_interface_valid  (if_valid),
        .interface_loopback_ready  (if_ready),
        .loopback_interface_data   (if_data),
        .interface_loopback_valid  (bus_valid),
        .loopback_interface_ready  (bus_ready),
        .interface_loopback_data   (bus_data),
        .loopback_postoffice_valid (rx_valid),
        .postoffice_loopback_ready (rx_ready),
        .loopback_postoffice_data  (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] msg(input logic [31:0] a, input logic [31:0] t,
                                         input logic [63:0] d);
        return {a, t, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h", tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; core_id = 32'd5;
        po_valid = 1'b0; po_data = '0; if_ready = 1'b0;
        bus_valid = 1'b0; bus_data = '0; rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // ---------------- reset state ----------------
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, '0);
        chk("rst_bus_ready", bus_ready, 1'b0);
        chk("rst_po_ready_ns", po_ready, 1'b0);
        po_data = msg(32'd5, 32'd0, 64'd0);
        #1 chk("rst_po_ready_self", po_ready, 1'b1);

        // ---------------- pass-through ----------------
        po_valid = 1'b1; po_data = msg(32'd7, 32'd3, 64'hAB); if_ready = 1'b1;
        #1;
        chk("pt_if_valid", if_valid, 1'b1);
        chk("pt_if_data", if_data, msg(32'd7, 32'd3, 64'hAB));
        chk("pt_po_ready", po_ready, 1'b1);
        chk("pt_rx_idle", rx_valid, 1'b0);
        tick();
        chk("pt_rx_idle_after", rx_valid, 1'b0);
        if_ready = 1'b0;
        #1 chk("pt_ready_follow", po_ready, 1'b0);

        // ---------------- loopback latency ----------------
        po_data = msg(32'd5, 32'd9, 64'h1234);
        #1;
        chk("lb_if_valid", if_valid, 1'b0);
        chk("lb_accept", po_ready, 1'b1);
        chk("lb_rx_before", rx_valid, 1'b0);
        tick();
        chk("lb_rx_valid", rx_valid, 1'b1);
        chk("lb_rx_data", rx_data, msg(32'd5, 32'd9, 64'h1234));
        chk("lb_if_valid2", if_valid, 1'b0);

        // ---------------- FIFO full ----------------
        po_data = msg(32'd5, 32'd9, 64'h1235);
        #1 chk("ff_accept2", po_ready, 1'b1);
        tick();
        po_data = msg(32'd5, 32'd9, 64'h1236);
        #1;
        chk("ff_full_ready", po_ready, 1'b0);
        chk("ff_head", rx_data, msg(32'd5, 32'd9, 64'h1234));
        tick();
        chk("ff_full_ready2", po_ready, 1'b0);
        chk("ff_head_stable", rx_data, msg(32'd5, 32'd9, 64'h1234));
        rx_ready = 1'b1;
        #1;
        chk("ff_no_same_cycle", po_ready, 1'b0);
        chk("ff_rx_valid", rx_valid, 1'b1);
        tick();
        rx_ready = 1'b0;
        #1;
        chk("ff_accept3", po_ready, 1'b1);
        chk("ff_head2", rx_data, msg(32'd5, 32'd9, 64'h1235));
        tick();
        po_valid = 1'b0;
        #1 chk("ff_head3", rx_data, msg(32'd5, 32'd9, 64'h1235));

        // ---------------- flush mid-operation ----------------
        flush = 1'b1; po_valid = 1'b1; po_data = msg(32'd5, 32'd0, 64'h77);
        #1;
        chk("fl_rx_valid", rx_valid, 1'b0);
        chk("fl_self_ready", po_ready, 1'b0);
        chk("fl_if_valid", if_valid, 1'b0);
        tick();
        flush = 1'b0; po_valid = 1'b0;
        #1;
        chk("fl_empty", rx_valid, 1'b0);
        chk("fl_rx_data", rx_data, '0);

        // ---------------- round-robin ----------------
        bus_valid = 1'b1; bus_data = msg(32'd9, 32'd1, 64'hB0); rx_ready = 1'b0;
        po_valid = 1'b1; po_data = msg(32'd5, 32'd2, 64'hA1);
        #1;
        chk("rr_bus_first", rx_data, msg(32'd9, 32'd1, 64'hB0));
        chk("rr_bus_ready0", bus_ready, 1'b0);
        tick();
        po_data = msg(32'd5, 32'd2, 64'hA2);
        #1 chk("rr_locked_b", rx_data, msg(32'd9, 32'd1, 64'hB0));
        tick();
        po_valid = 1'b0; rx_ready = 1'b1;
        #1;
        chk("rr_g1_b", rx_data, msg(32'd9, 32'd1, 64'hB0));
        chk("rr_g1_ready", bus_ready, 1'b1);
        tick();
        bus_data = msg(32'd9, 32'd1, 64'hB1);
        #1;
        chk("rr_g2_l", rx_data, msg(32'd5, 32'd2, 64'hA1));
        chk("rr_g2_ready", bus_ready, 1'b0);
        tick();
        chk("rr_g3_b", rx_data, msg(32'd9, 32'd1, 64'hB1));
        chk("rr_g3_ready", bus_ready, 1'b1);
        tick();
        bus_data = msg(32'd9, 32'd1, 64'hB2);
        #1 chk("rr_g4_l", rx_data, msg(32'd5, 32'd2, 64'hA2));
        tick();
        chk("rr_g5_b", rx_data, msg(32'd9, 32'd1, 64'hB2));
        tick();

        // ---------------- lock on L with prio_l = 1 ----------------
        bus_valid = 1'b0; rx_ready = 1'b0;
        po_valid = 1'b1; po_data = msg(32'd5, 32'd4, 64'hC3);
        #1 chk("lk_idle", rx_valid, 1'b0);
        tick();
        po_valid = 1'b0; bus_valid = 1'b1; bus_data = msg(32'd9, 32'd1, 64'hB3);
        #1;
        chk("lk_c0_data", rx_data, msg(32'd5, 32'd4, 64'hC3));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lk_hold_data", rx_data, msg(32'd5, 32'd4, 64'hC3));
            chk("lk_hold_valid", rx_valid, 1'b1);
            chk("lk_bus_ready", bus_ready, 1'b0);
        end
        rx_ready = 1'b1;
        #1 chk("lk_release", rx_data, msg(32'd5, 32'd4, 64'hC3));
        tick();
        chk("lk_next_b", rx_data, msg(32'd9, 32'd1, 64'hB3));
        chk("lk_next_ready", bus_ready, 1'b1);
        tick();
        bus_valid = 1'b0; rx_ready = 1'b0;

        // ---------------- reset mid-operation ----------------
        po_valid = 1'b1; po_data = msg(32'd5, 32'd6, 64'hD4);
        tick();
        po_valid = 1'b0;
        #1 chk("rs_pre", rx_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_post", rx_valid, 1'b0);
        chk("rs_post_data", rx_data, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/loopback_interceptor.md
Name: loopback_interceptor

Overview:
- Sits between the post office (send/receive queues) and the bus communication interface.
- Send side: a message whose destination address equals this core's id is diverted into a small loopback FIFO instead of going onto the bus. All other messages pass through to the bus interface unchanged.
- Receive side: merges bus-received messages and looped-back messages into a single receive stream toward the post office, using a locked round-robin arbiter.

Parameters:
- LOOPBACK_DEPTH, 2, number of entries in the loopback FIFO (≥1; any integer).

Ports:
- clk in 1: clock, all state on rising edge.
- rst in 1: synchronous, active-high reset.
- flush in 1: synchronous pipeline flush, same effect on state as rst.
- core_id in 32: this core's address; quasi-static.
- postoffice_loopback_valid in 1: send request valid.
- loopback_postoffice_ready out 1: send request accepted.
- postoffice_loopback_data in 128: interface_send_data_t; address[127:96], tag[95:64], data[63:0].
- loopback_interface_valid out 1: send toward bus interface.
- interface_loopback_ready in 1: bus interface can accept.
- loopback_interface_data out 128: interface_send_data_t.
- interface_loopback_valid in 1: message received from bus.
- loopback_interface_ready out 1: bus message accepted.
- interface_loopback_data in 128: interface_receive_data_t; address is the source.
- loopback_postoffice_valid out 1: receive message valid.
- postoffice_loopback_ready in 1: post office accepts the receive message.
- loopback_postoffice_data out 128: interface_receive_data_t.

Behaviour:
- Valid/ready handshake: a transfer occurs when valid && ready at a rising edge. Data must be held stable while valid && !ready.
- Self detection is combinational: is_self = (postoffice_loopback_data[127:96] == core_id).
- Send, not self:
  - loopback_interface_valid = postoffice_loopback_valid.
  - loopback_interface_data = postoffice_loopback_data.
  - loopback_postoffice_ready = interface_loopback_ready.
  - Zero latency, no state.
- Send, self:
  - loopback_interface_valid = 0.
  - loopback_postoffice_ready = !fifo_full && !flush.
  - On handshake, enqueue {address=core_id, tag, data}. The receive address field holds the source, which is self.
- loopback_postoffice_ready never depends on postoffice_loopback_ready; there is no same-cycle enqueue into a full FIFO, even when a dequeue occurs that cycle.
- FIFO:
  - Registered storage with wrap-around read/write pointers and an occupancy counter of width $clog2(LOOPBACK_DEPTH+1).
  - Simultaneous enqueue and dequeue leaves the count unchanged.
  - Minimum loopback latency is 1 cycle: enqueue at edge N, entry visible on the receive output after edge N.
- Receive arbiter, sources B (bus) and L (FIFO non-empty):
  - State: prio_l (reset 0, meaning B first); lock (reset 0); lock_src.
  - Unlocked: if only one source is valid, grant it. If both are valid, grant L when prio_l = 1, otherwise B.
  - If granted && !postoffice_loopback_ready, then lock = 1 and lock_src = granted source; the grant is held until handshake.
  - While locked, L stays valid by construction. B is granted as-is; if bus valid drops, the output valid drops and the lock releases.
  - On any receive handshake, prio_l = (granted source == B) and lock = 0.
  - loopback_postoffice_valid = valid of the granted source.
  - loopback_postoffice_data = data of the granted source.
  - loopback_interface_ready = postoffice_loopback_ready && grant == B.
  - FIFO dequeue = postoffice_loopback_ready && grant == L.
- Reset/flush:
  - State cleared at the edge: FIFO empty, pointers 0, prio_l = 0, lock = 0.
  - While flush = 1: L is masked from arbitration and self-addressed sends are not accepted.
  - The bus pass-through paths stay transparent.
  - rst mid-operation discards FIFO contents.
- Outputs after reset, with all inputs 0:
  - All valid outputs are 0.
  - loopback_postoffice_ready = 1 for a self send; otherwise it follows interface_loopback_ready.
  - Data outputs mirror inputs, or 0 for an empty FIFO with no bus valid.

Test Plan:
- Pass-through: core_id=5, send addr=7 tag=3 data=0xAB, interface ready=1 → loopback_interface_valid=1 with identical data, same cycle; receive stream stays idle.
- Loopback latency: core_id=5, send addr=5 data=0x1234 at edge N → loopback_postoffice_valid=1 after edge N, address=5, data=0x1234; bus output valid stays 0.
- FIFO full: LOOPBACK_DEPTH=2, postoffice_loopback_ready=0 held, three self sends → first two accepted, third sees ready=0 until one dequeue, then accepted the next cycle.
- Round-robin: FIFO holds 2 entries, bus valid continuously, receive ready=1 → grant order B, L, B, L; bus and loop data alternate on the output.
- Lock: both sources valid, prio_l=1, receive ready=0 for 3 cycles → grant L held for all 3 cycles with stable data; after ready=1, next grant is B.
- Flush mid-operation: FIFO holds 2 entries, assert flush for 1 cycle → no loopback output during flush; FIFO empty afterwards; a self send during flush sees ready=0.
